// File: rtl/fifo_multich_if.sv
// Bus bundle for the multichannel FIFO bank.
//
// Write side (one lane per channel):
//   wr_valid   per-channel write strobe
//   wr_data    packed write data, channel k at [k*CHANNEL_WIDTH +: CHANNEL_WIDTH]
//   wr_ready   per-channel not-full (held low until the bank leaves reset)
//   overflow   per-channel sticky flag: a write was attempted while full
//   ch_count   packed per-channel occupancy, CNT_W bits per channel
// Read side (single shared reader):
//   rd_select  requested read channel
//   rd_applied channel actually being served (pipelined echo of rd_select)
//   rd_en      pop the head of the applied channel
//   rd_valid   rd_data holds the head of the applied channel
//   rd_data    head word, registered
//
// master: producers plus read controller.  slave: the FIFO bank.
interface fifo_multich_if #(
  parameter int CHANNEL_WIDTH = 32,
  parameter int CHANNEL_CNT   = 5,
  parameter int CHANNEL_DEPTH = 1024
);
  localparam int SEL_W = $clog2(CHANNEL_CNT);
  localparam int CNT_W = $clog2(CHANNEL_DEPTH) + 1;

  logic [CHANNEL_CNT-1:0]               wr_valid;
  logic [CHANNEL_CNT*CHANNEL_WIDTH-1:0] wr_data;
  logic [CHANNEL_CNT-1:0]               wr_ready;
  logic [CHANNEL_CNT-1:0]               overflow;
  logic [CHANNEL_CNT*CNT_W-1:0]         ch_count;
  logic [SEL_W-1:0]                     rd_select;
  logic [SEL_W-1:0]                     rd_applied;
  logic                                 rd_en;
  logic                                 rd_valid;
  logic [CHANNEL_WIDTH-1:0]             rd_data;

  modport master (
    output wr_valid, wr_data, rd_select, rd_en,
    input  wr_ready, overflow, ch_count, rd_applied, rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_data, rd_select, rd_en,
    output wr_ready, overflow, ch_count, rd_applied, rd_valid, rd_data
  );
endinterface

// File: rtl/fifo_multich.sv
// Multichannel FIFO bank: the responder end of a read-select interface.
// CHANNEL_CNT independent circular buffers are written in parallel; one
// reader selects a channel, waits for rd_applied to echo it, then pops words
// through a show-ahead register (one word per two clocks sustained).
//
// Ports:
//   clk    single clock
//   rst_n  asynchronous active-low reset
//   bus    fifo_multich_if.slave (write lanes, status, read-select port)
module fifo_multich #(
  parameter int CHANNEL_WIDTH  = 32,
  parameter int CHANNEL_CNT    = 5,
  parameter int CHANNEL_DEPTH  = 1024,
  parameter int SELECT_LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  fifo_multich_if.slave bus
);
  localparam int PTR_W = $clog2(CHANNEL_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SEL_W = $clog2(CHANNEL_CNT);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CHANNEL_DEPTH);

  typedef enum logic [1:0] {SWITCH, EMPTY, FETCH, VALID} state_t;

  state_t                   state;
  logic                     released;
  logic [SEL_W-1:0]         sel_pipe [SELECT_LATENCY];
  logic [SEL_W-1:0]         applied;
  logic                     settled;
  logic                     pop;
  logic [CNT_W-1:0]         count    [CHANNEL_CNT];
  logic [CHANNEL_WIDTH-1:0] head     [CHANNEL_CNT];
  logic [CNT_W-1:0]         sel_count;
  logic [CHANNEL_WIDTH-1:0] sel_head;
  logic [CHANNEL_WIDTH-1:0] rd_data_q;

  assign applied        = sel_pipe[SELECT_LATENCY-1];
  assign bus.rd_applied = applied;
  assign bus.rd_data    = rd_data_q;
  // Valid is gated combinationally so it drops the moment the request moves
  // away from the channel being served, before the pipeline catches up.
  assign bus.rd_valid   = (state == VALID) && (bus.rd_select == applied);
  assign pop            = bus.rd_en && bus.rd_valid;

  // Out-of-range selects match no channel and so read as permanently empty.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    settled   = 1'b1;
    sel_count = '0;
    sel_head  = '0;
    for (int s = 0; s < SELECT_LATENCY; s++) begin
      if (sel_pipe[s] != bus.rd_select) settled = 1'b0;
    end
    for (int k = 0; k < CHANNEL_CNT; k++) begin
      if (applied == SEL_W'(k)) begin
        sel_count = count[k];
        sel_head  = head[k];
      end
    end
  end

  for (genvar k = 0; k < CHANNEL_CNT; k++) begin : g_ch
    logic [CHANNEL_WIDTH-1:0] mem [CHANNEL_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         cnt;
    logic                     ovf;
    logic                     full;
    logic                     wr_fire;
    logic                     pop_here;

    assign full     = (cnt == FULL_CNT);
    assign wr_fire  = bus.wr_valid[k] && released && !full;
    assign pop_here = pop && (applied == SEL_W'(k));

    assign bus.wr_ready[k] = released && !full;
    assign bus.overflow[k] = ovf;
    assign bus.ch_count[k*CNT_W +: CNT_W] = cnt;
    assign count[k] = cnt;
    assign head[k]  = mem[rd_ptr];

    // NOTE: the storage array is deliberately not reset; clearing the
    // pointers and count is enough to discard its contents.
    always_ff @(posedge clk) begin
      if (wr_fire) mem[wr_ptr] <= bus.wr_data[k*CHANNEL_WIDTH +: CHANNEL_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        ovf    <= 1'b0;
      end else begin
        if (wr_fire)  wr_ptr <= wr_ptr + 1'b1;
        if (pop_here) rd_ptr <= rd_ptr + 1'b1;
        if (bus.wr_valid[k] && full) ovf <= 1'b1;
        case ({wr_fire, pop_here})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SELECT_LATENCY; s++) sel_pipe[s] <= '0;
      state     <= SWITCH;
      rd_data_q <= '0;
      released  <= 1'b0;
    end else begin
      released    <= 1'b1;
      sel_pipe[0] <= bus.rd_select;
      for (int s = 1; s < SELECT_LATENCY; s++) sel_pipe[s] <= sel_pipe[s-1];

      if (!settled) begin
        state <= SWITCH;
      end else begin
        case (state)
          SWITCH: state <= (sel_count != '0) ? FETCH : EMPTY;
          EMPTY:  if (sel_count != '0) state <= FETCH;
          FETCH: begin
            if (sel_count == '0) begin
              state <= EMPTY;
            end else begin
              rd_data_q <= sel_head;
              state     <= VALID;
            end
          end
          VALID:  if (pop) state <= FETCH;
          default: state <= SWITCH;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fifo_multich.sv
// Directed self-checking bench for fifo_multich (default parameters).
module tb_fifo_multich;
  localparam int W     = 32;
  localparam int N     = 5;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  fifo_multich_if #(.CHANNEL_WIDTH(W), .CHANNEL_CNT(N), .CHANNEL_DEPTH(DEPTH)) bus ();

  fifo_multich #(
    .CHANNEL_WIDTH(W), .CHANNEL_CNT(N), .CHANNEL_DEPTH(DEPTH), .SELECT_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CNT_W-1:0] cnt(input int k);
    return bus.ch_count[k*CNT_W +: CNT_W];
  endfunction

  task automatic put(input int k, input logic [W-1:0] d);
    bus.wr_valid    = '0;
    bus.wr_valid[k] = 1'b1;
    bus.wr_data[k*W +: W] = d;
    tick();
    bus.wr_valid = '0;
  endtask

  task automatic pop_word();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!bus.rd_valid && n < 8) begin
      tick();
      n++;
    end
    check(tag, 64'(bus.rd_valid), 64'd1);
  endtask

  task automatic read_expect(input string tag, input logic [W-1:0] exp);
    wait_valid({tag, "_valid"});
    check(tag, 64'(bus.rd_data), 64'(exp));
    pop_word();
  endtask

  initial begin
    logic seen;
    n_checks = 0;
    n_fail   = 0;
    rst_n         = 1'b0;
    bus.wr_valid  = '0;
    bus.wr_data   = '0;
    bus.rd_select = 3'd2;
    bus.rd_en     = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_wr_ready", 64'(bus.wr_ready), 64'h0);
    check("rst_overflow", 64'(bus.overflow), 64'h0);
    check("rst_ch_count", 64'(bus.ch_count), 64'h0);
    check("rst_rd_applied", 64'(bus.rd_applied), 64'h0);
    check("rst_rd_valid", 64'(bus.rd_valid), 64'h0);
    check("rst_rd_data", 64'(bus.rd_data), 64'h0);
    rst_n = 1'b1;
    check("pre_release_ready", 64'(bus.wr_ready), 64'h0);
    tick();
    check("release_ready", 64'(bus.wr_ready), 64'h1f);
    repeat (3) tick();
    check("sel2_applied", 64'(bus.rd_applied), 64'd2);

    // Basic stream on ch2: valid two edges after the first accept
    bus.wr_valid[2] = 1'b1;
    bus.wr_data[2*W +: W] = 32'hA0;
    tick();
    check("a_valid_e0", 64'(bus.rd_valid), 64'd0);
    bus.wr_data[2*W +: W] = 32'hA1;
    tick();
    check("a_valid_e1", 64'(bus.rd_valid), 64'd0);
    bus.wr_data[2*W +: W] = 32'hA2;
    tick();
    check("a_valid_e2", 64'(bus.rd_valid), 64'd1);
    check("a_data_e2", 64'(bus.rd_data), 64'hA0);
    bus.wr_data[2*W +: W] = 32'hA3;
    tick();
    bus.wr_valid = '0;
    check("a_count4", 64'(cnt(2)), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check("a_head_valid", 64'(bus.rd_valid), 64'd1);
      check("a_head_data", 64'(bus.rd_data), 64'(32'hA0 + i));
      pop_word();
      check("a_bubble", 64'(bus.rd_valid), 64'd0);
      tick();
    end
    check("a_count0", 64'(cnt(2)), 64'd0);
    tick();
    check("a_empty_valid", 64'(bus.rd_valid), 64'd0);

    // Fill ch0, overflow, then read back across the pointer wrap
    bus.wr_valid[0] = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.wr_data[0 +: W] = 32'h1000 + i;
      tick();
    end
    check("b_full_count", 64'(cnt(0)), 64'd1024);
    check("b_full_ready", 64'(bus.wr_ready), 64'h1e);
    bus.wr_data[0 +: W] = 32'hDEAD;
    tick();
    bus.wr_valid = '0;
    check("b_overflow", 64'(bus.overflow), 64'h01);
    check("b_count_held", 64'(cnt(0)), 64'd1024);
    bus.rd_select = 3'd0;
    for (int i = 0; i < DEPTH; i++) read_expect("b_readback", 32'h1000 + i);
    check("b_count0", 64'(cnt(0)), 64'd0);
    check("b_overflow_sticky", 64'(bus.overflow), 64'h01);
    check("b_ready_again", 64'(bus.wr_ready), 64'h1f);

    // Channel switch 1 -> 3
    bus.wr_valid = 5'b01010;
    bus.wr_data[1*W +: W] = 32'h11;
    bus.wr_data[3*W +: W] = 32'h33;
    tick();
    bus.wr_valid = '0;
    bus.rd_select = 3'd1;
    wait_valid("c_ch1_valid");
    check("c_ch1_data", 64'(bus.rd_data), 64'h11);
    bus.rd_select = 3'd3;
    #1;
    check("c_drop_same_cycle", 64'(bus.rd_valid), 64'd0);
    tick();
    check("c_applied_s0", 64'(bus.rd_applied), 64'd1);
    tick();
    check("c_applied_s1", 64'(bus.rd_applied), 64'd3);
    check("c_valid_s1", 64'(bus.rd_valid), 64'd0);
    tick();
    check("c_valid_s2", 64'(bus.rd_valid), 64'd0);
    tick();
    check("c_valid_s3", 64'(bus.rd_valid), 64'd1);
    check("c_ch3_data", 64'(bus.rd_data), 64'h33);
    pop_word();

    // rd_en on an empty channel, then an out-of-range select
    bus.rd_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen |= bus.rd_valid;
    end
    check("d_no_valid", 64'(seen), 64'd0);
    check("d_count3", 64'(cnt(3)), 64'd0);
    check("d_count1", 64'(cnt(1)), 64'd1);
    check("d_data_held", 64'(bus.rd_data), 64'h33);
    bus.rd_select = 3'd7;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen |= bus.rd_valid;
    end
    bus.rd_en = 1'b0;
    check("d_sel7_applied", 64'(bus.rd_applied), 64'd7);
    check("d_sel7_no_valid", 64'(seen), 64'd0);
    check("d_sel7_counts", 64'(bus.ch_count), 64'(11'd1) << CNT_W);

    // Simultaneous write and pop on ch4 at count 5
    bus.rd_select = 3'd4;
    for (int i = 0; i < 5; i++) put(4, 32'h40 + i);
    check("e_count5", 64'(cnt(4)), 64'd5);
    wait_valid("e_valid");
    check("e_head", 64'(bus.rd_data), 64'h40);
    bus.wr_valid[4] = 1'b1;
    bus.wr_data[4*W +: W] = 32'h45;
    bus.rd_en = 1'b1;
    tick();
    bus.wr_valid = '0;
    bus.rd_en    = 1'b0;
    check("e_count_same", 64'(cnt(4)), 64'd5);
    for (int i = 1; i <= 5; i++) read_expect("e_order", 32'h40 + i);
    check("e_count0", 64'(cnt(4)), 64'd0);

    // Asynchronous reset mid-stream
    bus.rd_select = 3'd2;
    for (int i = 0; i < 3; i++) put(2, 32'hB0 + i);
    wait_valid("f_valid");
    check("f_count3", 64'(cnt(2)), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("f_rst_counts", 64'(bus.ch_count), 64'h0);
    check("f_rst_valid", 64'(bus.rd_valid), 64'd0);
    check("f_rst_ready", 64'(bus.wr_ready), 64'h0);
    check("f_rst_applied", 64'(bus.rd_applied), 64'd0);
    check("f_rst_overflow", 64'(bus.overflow), 64'h0);
    #2;
    rst_n = 1'b1;
    #1;
    check("f_ready_before_edge", 64'(bus.wr_ready), 64'h0);
    tick();
    check("f_ready_after_edge", 64'(bus.wr_ready), 64'h1f);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
